// File: rtl/port_rx.sv
// Switch output-port receiver: pulls bytes through a 2-entry skid buffer and frames DA/LEN/payload/PAR packets.
// Optional `define PORT_RX_STATS_EN adds saturating pkt_cnt/err_cnt outputs.
module port_rx #(
    parameter int MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready_i,
    output logic       read_o,
    input  logic [7:0] port_i,
    input  logic [7:0] port_addr,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sop,
    output logic       out_eop,
    output logic       out_err
`ifdef PORT_RX_STATS_EN
    ,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt
`endif
);

    typedef enum logic [1:0] {S_DA, S_LEN, S_DATA, S_PAR} state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    logic [7:0] skid0, skid1;
    logic [1:0] occ;
    logic       rd_q;
    state_t     state;
    logic [7:0] xor_r;
    logic [7:0] cnt;
    logic       err;
    logic       pop;
    logic [2:0] pending;

    assign out_valid = reset & (occ != 2'd0);
    assign pop       = out_valid & out_ready;
    // Occupancy after this cycle's pop plus the read still in flight; keeps 1 byte/cycle with out_ready high.
    assign pending   = {1'b0, occ} - {2'b00, pop} + {2'b00, rd_q};
    assign read_o    = reset & ready_i & (pending < 3'd2);
    assign out_data  = out_valid ? skid0 : 8'h00;
    assign out_sop   = out_valid & (state == S_DA);
    assign out_eop   = out_valid & (state == S_PAR);
    assign out_err   = out_eop & (err | (skid0 != xor_r));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid0 <= 8'h00;
            skid1 <= 8'h00;
            occ   <= 2'd0;
            rd_q  <= 1'b0;
        end else begin
            rd_q <= read_o;
            case ({rd_q, pop})
                2'b10: begin
                    if (occ == 2'd0) skid0 <= port_i;
                    else             skid1 <= port_i;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    skid0 <= skid1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        skid0 <= port_i;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= port_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_DA;
            xor_r <= 8'h00;
            cnt   <= 8'h00;
            err   <= 1'b0;
        end else if (pop) begin
            case (state)
                S_DA: begin
                    xor_r <= skid0;
                    err   <= (skid0 != port_addr);
                    state <= S_LEN;
                end
                S_LEN: begin
                    xor_r <= xor_r ^ skid0;
                    cnt   <= skid0;
                    if (skid0 == 8'h00 || skid0 > MAX_B) err <= 1'b1;
                    state <= (skid0 != 8'h00) ? S_DATA : S_PAR;
                end
                S_DATA: begin
                    xor_r <= xor_r ^ skid0;
                    cnt   <= cnt - 8'd1;
                    if (cnt == 8'd1) state <= S_PAR;
                end
                default: begin
                    err   <= 1'b0;
                    state <= S_DA;
                end
            endcase
        end
    end

`ifdef PORT_RX_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt <= 16'h0000;
            err_cnt <= 16'h0000;
        end else if (pop && out_eop) begin
            if (pkt_cnt != 16'hFFFF)            pkt_cnt <= pkt_cnt + 16'd1;
            if (out_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_port_rx.sv
// Directed bench for port_rx: a queue-based switch FIFO model feeds packets, a scoreboard checks every accepted beat.
module tb_port_rx;
    localparam int MAX_LEN = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ready_i = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] port_i = 8'h00;
    logic [7:0] port_addr = 8'h55;
    logic       read_o, out_valid, out_sop, out_eop, out_err;
    logic [7:0] out_data;
`ifdef PORT_RX_STATS_EN
    logic [15:0] pkt_cnt, err_cnt;
`endif

    port_rx #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset(reset), .ready_i(ready_i), .read_o(read_o),
        .port_i(port_i), .port_addr(port_addr), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
        .out_eop(out_eop), .out_err(out_err)
`ifdef PORT_RX_STATS_EN
        , .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic       err;
        logic [7:0] data;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] fifo[$];
    int         vecs = 0, fails = 0;
    int         beat_cnt = 0, run = 0, max_run = 0;
    logic       rd_now = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vecs++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Switch FIFO: a read sampled in one cycle delivers its byte right after the next rising edge.
    always @(posedge clk) begin
        if (rd_now && reset && fifo.size() != 0) port_i <= fifo.pop_front();
        ready_i <= (fifo.size() != 0);
    end

    always @(negedge clk) begin
        beat_t got;
        rd_now = read_o;
        run = read_o ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (reset && out_valid && out_ready) begin
            beat_cnt++;
            got = {out_sop, out_eop, out_err, out_data};
            chk("sop_and_eop", {31'd0, out_sop & out_eop}, 32'd0);
            if (exp_q.size() == 0) chk("extra_beat", {20'd0, got}, 32'hFFFFFFFF);
            else                   chk("beat", {20'd0, got}, {20'd0, exp_q.pop_front()});
        end
    end

    task automatic send_pkt(input logic [7:0] da, input logic [7:0] len,
                            input logic [7:0] base, input logic [7:0] flip);
        logic [7:0] x, b;
        logic       e;
        x = da ^ len;
        e = (da != port_addr) || (len == 8'd0) || (int'(len) > MAX_LEN) || (flip != 8'd0);
        fifo.push_back(da);
        fifo.push_back(len);
        exp_q.push_back({1'b1, 1'b0, 1'b0, da});
        exp_q.push_back({1'b0, 1'b0, 1'b0, len});
        for (int i = 0; i < int'(len); i++) begin
            b = base + 8'(i * 8'h11);
            x = x ^ b;
            fifo.push_back(b);
            exp_q.push_back({1'b0, 1'b0, 1'b0, b});
        end
        fifo.push_back(x ^ flip);
        exp_q.push_back({1'b0, 1'b1, e, x ^ flip});
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 200 && beat_cnt < n; i++) @(negedge clk);
        chk("wait_beats", {31'd0, beat_cnt >= n}, 32'd1);
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_read_o"}, {31'd0, read_o}, 32'd0);
        chk({tag, "_out"}, {20'd0, out_valid, out_sop, out_eop, out_err, out_data}, 32'd0);
    endtask

    initial begin
        logic [7:0] held;
        int b0;
        #1;
        chk_zero_outs("reset");
`ifdef PORT_RX_STATS_EN
        chk("reset_stats", {pkt_cnt, err_cnt}, 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Good packet: read_o must run 6 cycles straight.
        max_run = 0;
        send_pkt(8'h55, 8'd3, 8'hA1, 8'h00);
        drain();
        chk("read_run", max_run, 6);

        send_pkt(8'h55, 8'd3, 8'hA1, 8'h01);
        drain();
        send_pkt(8'h66, 8'd4, 8'h10, 8'h00);
        drain();
        send_pkt(8'h55, 8'd0, 8'h00, 8'h00);
        drain();
        send_pkt(8'h55, 8'(MAX_LEN + 1), 8'h07, 8'h00);
        drain();
        send_pkt(8'h55, 8'(MAX_LEN), 8'h3C, 8'h00);
        drain();

        // Downstream stall mid-payload.
        b0 = beat_cnt;
        send_pkt(8'h55, 8'd8, 8'h20, 8'h00);
        wait_beats(b0 + 4);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_read_o", {31'd0, read_o}, 32'd0);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", {24'd0, out_data}, {24'd0, held});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Reset mid-payload, then a clean packet.
        b0 = beat_cnt;
        send_pkt(8'h55, 8'd6, 8'h40, 8'h00);
        wait_beats(b0 + 3);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        fifo.delete();
        #1;
        chk_zero_outs("midreset");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_pkt(8'h55, 8'd4, 8'h81, 8'h00);
        drain();
`ifdef PORT_RX_STATS_EN
        chk("stats_after_reset", {pkt_cnt, err_cnt}, {16'd1, 16'd0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/port_rx.md
PORT_RX -- requirements
Module: port_rx

Interface
REQ-001 Parameter: MAX_LEN, default 64, largest legal payload length in bytes (1..255).
REQ-002 clk  input  1  rising-edge clock, shared with the switch.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ready_i  input  1  switch output-port "FIFO not empty" (ready_N).
REQ-005 read_o  output  1  switch output-port read strobe (read_N).
REQ-006 port_i  input  8  switch output-port data (portN), valid in the cycle after a read edge.
REQ-007 port_addr  input  8  address programmed for this port (mem[N]), static while packets flow.
REQ-008 out_data  output  8  reassembled packet byte.
REQ-009 out_valid  output  1  out_data/out_sop/out_eop/out_err valid.
REQ-010 out_ready  input  1  downstream accepts the beat when out_valid&out_ready at a rising edge.
REQ-011 out_sop  output  1  beat is the destination-address byte.
REQ-012 out_eop  output  1  beat is the parity byte.
REQ-013 out_err  output  1  packet error, meaningful only with out_eop.

Function
REQ-014 Packet format: DA, LEN, LEN payload bytes, PAR; PAR = XOR of DA, LEN and all payload bytes.
REQ-015 read_o SHALL be combinational: ready_i & (skid occupancy + reads in flight < 2).
REQ-016 A read issued at edge N SHALL capture port_i at edge N+1 into a 2-entry skid buffer; back-to-back reads allowed (1 byte/cycle).
REQ-017 Parser FSM states: S_DA, S_LEN, S_DATA, S_PAR, advancing once per byte popped from the skid head.
REQ-018 S_DA: pop marks out_sop=1, latches running XOR = byte, sets err if byte != port_addr, goes to S_LEN.
REQ-019 S_LEN: latches count = byte, sets err if byte == 0 or byte > MAX_LEN, goes to S_DATA (LEN != 0) else S_PAR.
REQ-020 S_DATA: each pop decrements count; pop with count == 1 goes to S_PAR.
REQ-021 S_PAR: pop marks out_eop=1, out_err = err | (byte != running XOR), goes to S_DA, clears err.
REQ-022 Skid head is presented on out_* combinationally; pop occurs only on out_valid & out_ready.
REQ-023 out_ready low SHALL hold out_* stable and stop read_o once occupancy + in-flight reaches 2; no byte is dropped or duplicated.
REQ-024 ready_i falling mid-packet SHALL only stall; parser state and count are retained indefinitely.
REQ-025 An erroneous packet is still forwarded in full (LEN bytes honoured when LEN <= 255); only out_err differs.
REQ-026 out_sop and out_eop SHALL never both be 1 on one beat.

Reset
REQ-027 reset low SHALL immediately force read_o=0, out_valid=0, out_sop=0, out_eop=0, out_err=0, out_data=0.
REQ-028 Reset SHALL empty the skid buffer, cancel reads in flight, clear XOR/count/err, and put FSM in S_DA.
REQ-029 Reset mid-packet discards the partial packet; next byte after release is treated as DA.

Configuration
REQ-030 Macro PORT_RX_STATS_EN defined: extra outputs pkt_cnt[15:0] and err_cnt[15:0] exist, incremented on each accepted eop beat (err_cnt only when out_err=1), saturating at 16'hFFFF, reset to 0.
REQ-031 PORT_RX_STATS_EN undefined: pkt_cnt/err_cnt ports and logic are absent; all other behaviour is identical.

Verification
REQ-032 port_addr=8'h55, FIFO holds 55,03,A1,B2,C3,PAR=8'hC3^... (correct), out_ready=1 -> 6 beats, sop on 55, eop on parity, out_err=0, read_o high 6 consecutive cycles.
REQ-033 Same packet with PAR bit-flipped -> all 6 beats forwarded, out_err=1 on eop beat only.
REQ-034 DA=8'h66 with port_addr=8'h55, valid PAR -> packet forwarded, out_err=1 on eop.
REQ-035 LEN=0 then PAR=DA^00 -> 3 beats, out_err=1 (zero length); LEN=MAX_LEN+1 -> out_err=1.
REQ-036 out_ready held low 10 cycles mid-payload -> read_o stops after 2 bytes buffered, out_data stable, output sequence unchanged after release.
REQ-037 reset pulsed low during payload byte 2 -> outputs 0 within same cycle; following clean packet parsed from DA with out_err=0; with PORT_RX_STATS_EN, pkt_cnt=1, err_cnt=0 after it.
